// File: rtl/led_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// led_pkg: mode and FSM state encodings shared by the LED sequencer files
// Rev 1.0
// ----------------------------------------------------------------------------
package led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_CHASE  = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_ACKWAIT = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/led_sequencer_tick_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tick_gen: prescaler producing a one-cycle tick every TICK_DIV enabled clocks
// Rev 1.0
// ----------------------------------------------------------------------------
module tick_gen #(
  parameter int unsigned TICK_BITS = 24,
  parameter int unsigned TICK_DIV  = 8_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam logic [TICK_BITS-1:0] C_LAST = TICK_BITS'(TICK_DIV - 1);

  logic [TICK_BITS-1:0] cnt_q;

  // Gating with enable means a tick that coincides with enable low is simply lost.
  assign tick = enable && !clear && (cnt_q == C_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= tick ? '0 : cnt_q + TICK_BITS'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/led_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// led_sequencer: off/blink/chase/bounce LED pattern stepper, modes loaded at step boundaries
// Rev 1.0
// ----------------------------------------------------------------------------
module led_sequencer
  import led_pkg::*;
#(
  parameter int unsigned N_LEDS    = 8,
  parameter int unsigned TICK_BITS = 24,
  parameter int unsigned TICK_DIV  = 8_000_000,
  parameter int unsigned STEP_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [1:0]           mode,
  input  logic                 mode_req,
  output logic                 mode_ack,
  input  logic [STEP_BITS-1:0] steps,
  output logic [N_LEDS-1:0]    leds,
  output logic                 step_pulse,
  output logic                 busy
);

  state_e               state_q, ret_q;
  mode_e                mode_q;
  logic                 dir_q;
  logic [N_LEDS-1:0]    leds_q;
  logic                 ack_q, pulse_q, busy_q;
  logic [STEP_BITS-1:0] step_cnt_q, steps_q;

  logic                 w_tick, w_run, w_boundary;
  logic [STEP_BITS:0]   w_steps_eff, w_cnt_inc;
  mode_e                w_req_mode;
  state_e               w_load_ret;
  logic [N_LEDS-1:0]    w_load_leds, w_adv, w_bounce_next;
  logic                 w_bounce_dir;

  assign w_req_mode  = mode_e'(mode);
  assign w_run       = (state_q == ST_RUN) || ((state_q == ST_ACKWAIT) && (ret_q == ST_RUN));
  assign w_steps_eff = (steps_q == '0) ? (STEP_BITS+1)'(1) : {1'b0, steps_q};
  assign w_cnt_inc   = {1'b0, step_cnt_q} + (STEP_BITS+1)'(1);
  assign w_boundary  = w_run && w_tick && (w_cnt_inc >= w_steps_eff);

  assign w_load_ret  = (w_req_mode == MODE_OFF) ? ST_IDLE : ST_RUN;
  assign w_load_leds = (w_req_mode == MODE_OFF)   ? '0 :
                       (w_req_mode == MODE_BLINK) ? '1 : N_LEDS'(1);

  tick_gen #(
    .TICK_BITS (TICK_BITS),
    .TICK_DIV  (TICK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .enable (enable && w_run),
    .clear  (state_q == ST_IDLE),
    .tick   (w_tick)
  );

  generate
    if (N_LEDS == 1) begin : g_bounce_single
      assign w_bounce_next = leds_q;
      assign w_bounce_dir  = 1'b1;
    end else begin : g_bounce_multi
      // Direction flips on the step that lands on an end LED, not the one after.
      always_comb begin
        w_bounce_next = dir_q ? (leds_q << 1) : (leds_q >> 1);
        w_bounce_dir  = dir_q;
        if (dir_q && w_bounce_next[N_LEDS-1]) begin
          w_bounce_dir = 1'b0;
        end else if (!dir_q && w_bounce_next[0]) begin
          w_bounce_dir = 1'b1;
        end
      end
    end
  endgenerate

  always_comb begin
    w_adv = leds_q;
    case (mode_q)
      MODE_BLINK:  w_adv = ~leds_q;
      MODE_CHASE:  w_adv = (leds_q << 1) | (leds_q >> (N_LEDS - 1));
      MODE_BOUNCE: w_adv = w_bounce_next;
      default:     w_adv = leds_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      ret_q      <= ST_IDLE;
      mode_q     <= MODE_OFF;
      dir_q      <= 1'b1;
      leds_q     <= '0;
      ack_q      <= 1'b0;
      pulse_q    <= 1'b0;
      busy_q     <= 1'b0;
      step_cnt_q <= '0;
      steps_q    <= '0;
    end else begin
      pulse_q <= 1'b0;

      if ((state_q == ST_IDLE) || w_boundary) begin
        step_cnt_q <= '0;
        steps_q    <= steps;
      end else if (w_run && w_tick) begin
        step_cnt_q <= w_cnt_inc[STEP_BITS-1:0];
      end

      case (state_q)
        ST_IDLE: begin
          leds_q <= '0;
          if (mode_req) begin
            leds_q  <= w_load_leds;
            mode_q  <= w_req_mode;
            dir_q   <= 1'b1;
            ret_q   <= w_load_ret;
            pulse_q <= (w_req_mode != MODE_OFF);
            ack_q   <= 1'b1;
            state_q <= ST_ACKWAIT;
          end
        end
        ST_RUN: begin
          if (w_boundary) begin
            pulse_q <= 1'b1;
            if (mode_req) begin
              leds_q  <= w_load_leds;
              mode_q  <= w_req_mode;
              dir_q   <= 1'b1;
              ret_q   <= w_load_ret;
              ack_q   <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_ACKWAIT;
            end else begin
              leds_q <= w_adv;
              if (mode_q == MODE_BOUNCE) dir_q <= w_bounce_dir;
            end
          end
        end
        ST_ACKWAIT: begin
          if (w_boundary) begin
            pulse_q <= 1'b1;
            leds_q  <= w_adv;
            if (mode_q == MODE_BOUNCE) dir_q <= w_bounce_dir;
          end
          if (!mode_req) begin
            ack_q   <= 1'b0;
            state_q <= ret_q;
            busy_q  <= (ret_q == ST_RUN);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign leds       = leds_q;
  assign mode_ack   = ack_q;
  assign step_pulse = pulse_q;
  assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_led_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_led_sequencer: directed vector bench for led_sequencer (N_LEDS=4, TICK_DIV=4)
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_led_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b1;
  logic [1:0] mode = 2'd0;
  logic       mode_req = 1'b0;
  logic       mode_ack;
  logic [3:0] steps = 4'd1;
  logic [3:0] leds;
  logic       step_pulse;
  logic       busy;

  int checks = 0;
  int errors = 0;
  logic [3:0] cur_leds;

  typedef struct {
    logic       req;
    logic [1:0] md;
    logic [3:0] st;
    logic       en;
    logic [3:0] e_leds;
    logic       e_ack;
    logic       e_pulse;
    logic       e_busy;
  } vec_t;

  vec_t vecs[$];

  led_sequencer #(
    .N_LEDS    (4),
    .TICK_BITS (8),
    .TICK_DIV  (4),
    .STEP_BITS (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .mode       (mode),
    .mode_req   (mode_req),
    .mode_ack   (mode_ack),
    .steps      (steps),
    .leds       (leds),
    .step_pulse (step_pulse),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [3:0] el, input logic ea,
                         input logic ep, input logic eb);
    chk({nm, " leds"}, 32'(leds), 32'(el));
    chk({nm, " ack"}, 32'(mode_ack), 32'(ea));
    chk({nm, " pulse"}, 32'(step_pulse), 32'(ep));
    chk({nm, " busy"}, 32'(busy), 32'(eb));
  endtask

  // hold clocks with the pattern unchanged, then one clock that must advance to nxt
  task automatic expect_step(input string nm, input int hold, input logic [3:0] nxt);
    for (int i = 0; i < hold; i++) begin
      step();
      chk({nm, " hold leds"}, 32'(leds), 32'(cur_leds));
      chk({nm, " hold pulse"}, 32'(step_pulse), 32'd0);
    end
    step();
    chk({nm, " step leds"}, 32'(leds), 32'(nxt));
    chk({nm, " step pulse"}, 32'(step_pulse), 32'd1);
    cur_leds = nxt;
  endtask

  function automatic void add(input logic rq, input logic [1:0] md, input logic [3:0] st,
                              input logic en, input logic [3:0] el, input logic ea,
                              input logic ep, input logic eb);
    vec_t v;
    v.req = rq; v.md = md; v.st = st; v.en = en;
    v.e_leds = el; v.e_ack = ea; v.e_pulse = ep; v.e_busy = eb;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [3:0] bpat [7];
    bpat = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};

    // BOUNCE, steps=1: load on request edge, then one step every 4 clocks
    add(1'b1, 2'd3, 4'd1, 1'b1, 4'b0001, 1'b1, 1'b1, 1'b0);
    add(1'b0, 2'd3, 4'd1, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b1);
    add(1'b0, 2'd3, 4'd1, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b1);
    add(1'b0, 2'd3, 4'd1, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b1);
    for (int p = 0; p < 7; p++) begin
      add(1'b0, 2'd3, 4'd1, 1'b1, bpat[p], 1'b0, 1'b1, 1'b1);
      for (int h = 0; h < 3; h++) add(1'b0, 2'd3, 4'd1, 1'b1, bpat[p], 1'b0, 1'b0, 1'b1);
    end

    #1;
    chk_all("reset", 4'b0000, 1'b0, 1'b0, 1'b0);
    step();
    step();
    rst = 1'b1;
    step();
    chk_all("post reset idle", 4'b0000, 1'b0, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      mode_req = vecs[i].req;
      mode     = vecs[i].md;
      steps    = vecs[i].st;
      enable   = vecs[i].en;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].e_leds, vecs[i].e_ack,
              vecs[i].e_pulse, vecs[i].e_busy);
    end

    // asynchronous reset mid-run
    #2 rst = 1'b0;
    #1;
    chk_all("async reset", 4'b0000, 1'b0, 1'b0, 1'b0);
    step();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("idle after reset", 4'b0000, 1'b0, 1'b0, 1'b0);
    end

    // CHASE from IDLE, steps=2: 8 clocks per step
    mode = 2'd2; steps = 4'd2; mode_req = 1'b1;
    step();
    chk_all("chase load", 4'b0001, 1'b1, 1'b1, 1'b0);
    mode_req = 1'b0;
    step();
    chk_all("chase ack drop", 4'b0001, 1'b0, 1'b0, 1'b1);
    cur_leds = 4'b0001;
    expect_step("chase1", 6, 4'b0010);
    expect_step("chase2", 7, 4'b0100);
    expect_step("chase3", 7, 4'b1000);
    expect_step("chase4", 7, 4'b0001);

    // BLINK requested 3 clocks after a step waits for the boundary
    for (int i = 0; i < 3; i++) step();
    mode = 2'd1; mode_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_all("midreq wait", 4'b0001, 1'b0, 1'b0, 1'b1);
    end
    step();
    chk_all("midreq load", 4'b1111, 1'b1, 1'b1, 1'b0);
    mode_req = 1'b0;
    step();
    chk_all("midreq ack drop", 4'b1111, 1'b0, 1'b0, 1'b1);
    cur_leds = 4'b1111;
    expect_step("blink", 6, 4'b0000);

    // CHASE with steps=0 acts as steps=1
    steps = 4'd0; mode = 2'd2; mode_req = 1'b1;
    expect_step("zero load", 7, 4'b0001);
    chk("zero load ack", 32'(mode_ack), 32'd1);
    mode_req = 1'b0;
    step();
    chk("zero ack drop", 32'(mode_ack), 32'd0);
    expect_step("zero step", 2, 4'b0010);

    // freeze mid-count, then resume where it stopped
    step();
    step();
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_all("freeze", 4'b0010, 1'b0, 1'b0, 1'b1);
    end
    enable = 1'b1;
    expect_step("resume", 1, 4'b0100);

    // freeze on the tick cycle itself: tick is lost, counters hold
    for (int i = 0; i < 3; i++) step();
    enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk_all("tick freeze", 4'b0100, 1'b0, 1'b0, 1'b1);
    end
    enable = 1'b1;
    expect_step("tick resume", 0, 4'b1000);

    // OFF request in RUN
    mode = 2'd0; mode_req = 1'b1;
    expect_step("off", 3, 4'b0000);
    chk("off ack", 32'(mode_ack), 32'd1);
    chk("off busy", 32'(busy), 32'd0);
    mode_req = 1'b0;
    step();
    chk_all("off ack drop", 4'b0000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("off idle", 4'b0000, 1'b0, 1'b0, 1'b0);
    end
    mode = 2'd1; mode_req = 1'b1;
    step();
    chk_all("idle accept", 4'b1111, 1'b1, 1'b1, 1'b0);
    mode_req = 1'b0;
    step();
    chk_all("idle accept drop", 4'b1111, 1'b0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/led_sequencer.md
# led_sequencer

Controller that sequences the LED flasher outputs on the Papilio Pro. It owns a prescaler and a step counter, and steps an N-LED pattern through one of four modes: off, blink, chase, bounce. Mode changes arrive over a four-phase req/ack handshake from the host logic (buttons or a UART command decoder) and are applied only at step boundaries, so the visible pattern never glitches.

## Interface
- `N_LEDS`, 8: pattern width; must be ≥ 1.
- `TICK_BITS`, 24: prescaler counter width.
- `TICK_DIV`, 8_000_000: clocks per tick; must be ≥ 1 and < 2^TICK_BITS.
- `STEP_BITS`, 4: width of the `steps` input.
- `clk`, in, 1: system clock. The block uses one clock only.
- `rst`, in, 1: asynchronous, active-low reset.
- `enable`, in, 1: when low, the prescaler, step counter and pattern freeze.
- `mode`, in, 2: requested mode. 0 = OFF, 1 = BLINK, 2 = CHASE, 3 = BOUNCE. Must be stable while `mode_req` is high.
- `mode_req`, in, 1: four-phase request.
- `mode_ack`, out, 1: four-phase acknowledge.
- `steps`, in, STEP_BITS: ticks per pattern step. A value of 0 is treated as 1. Sampled whenever the step counter reloads.
- `leds`, out, N_LEDS: pattern output, registered.
- `step_pulse`, out, 1: one-cycle pulse each time the pattern advances or loads.
- `busy`, out, 1: high while the state is RUN.

## Operation
- The FSM has three states: IDLE, RUN, ACKWAIT.
- **IDLE**
  - `leds` = 0.
  - On `mode_req`=1 with mode≠OFF: load the initial pattern, clear the prescaler and step counter, raise `mode_ack`, go to ACKWAIT, and latch the return state RUN.
  - On `mode_req`=1 with mode=OFF: raise `mode_ack`, go to ACKWAIT, return state IDLE.
  - In IDLE a request is accepted regardless of `enable`.
- **RUN**
  - The prescaler counts while `enable`=1. `tick` is internal, high for one cycle when the count = TICK_DIV−1; the count then wraps to 0.
  - The step counter counts ticks. When it reaches max(steps,1) a step boundary occurs: the counter returns to 0 and `step_pulse`=1.
  - If `mode_req`=1 at the step boundary, the mode load wins over the normal advance:
    - mode≠OFF: load the initial pattern.
    - mode=OFF: `leds` ← 0 and the return state is IDLE.
    - In both cases raise `mode_ack` and go to ACKWAIT.
  - A request that arrives between boundaries waits. If `enable`=0, it waits indefinitely.
- **ACKWAIT**
  - `mode_ack` stays high until `mode_req` is sampled low.
  - `mode_ack` drops on the cycle after that sample, and the FSM goes to the return state.
  - The pattern keeps running in ACKWAIT when the return state is RUN. Further requests are ignored until the FSM leaves ACKWAIT.
- **Initial patterns and advance rules**
  - BLINK: initial all-ones; each step inverts all bits.
  - CHASE: initial 1 (LSB set); each step rotates left, so the MSB wraps to the LSB.
  - BOUNCE: initial 1 with direction up.
    - Each step shifts in the current direction.
    - The direction reverses on the step that reaches the MSB or the LSB.
    - When N_LEDS=1 the pattern stays at 1.
- A mode load discards the current phase: the direction resets to up and the blink phase resets to on.

## Timing
- Reset values: `leds`=0, `mode_ack`=0, `step_pulse`=0, `busy`=0, state IDLE, all counters 0.
- `rst` assertion mid-run clears everything within the same cycle (asynchronous). Deassertion must be synchronised externally.
- IDLE accept latency: request sampled at edge k → `leds` and `mode_ack` valid after edge k.
- From the load, the first advance occurs max(steps,1)·TICK_DIV enabled clocks later.
- `step_pulse` coincides with the cycle in which `leds` shows the new value.
- `enable` deasserted exactly on a tick cycle: that tick is lost and the counters hold.

## Structure
- The shared package `led_pkg` holds:
  - the mode encodings MODE_OFF/BLINK/CHASE/BOUNCE;
  - the FSM state encodings.
- Sub-module `tick_gen`: the prescaler, with parameters TICK_BITS and TICK_DIV; inputs clk, rst, enable, clear; output tick.
- The FSM, step counter and pattern logic stay in `led_sequencer`.

## Test plan
All scenarios use TICK_DIV=4, N_LEDS=4.

- **Reset:** hold `rst`=0 mid-RUN → `leds`=0000, `mode_ack`=0, `busy`=0 immediately; after release the block sits in IDLE.
- **CHASE from IDLE:** steps=2 → `leds`=0001 after the request edge; then 0010, 0100, 1000, 0001, each 8 clocks apart, with a `step_pulse` each time; `mode_ack` drops one cycle after `mode_req` falls.
- **BOUNCE:** steps=1 → 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010 at 4-clock intervals.
- **Mid-step request:** BLINK requested 3 clocks after a CHASE step → `leds` stays unchanged until the next boundary, then shows 1111 and `mode_ack` rises on that same edge.
- **Freeze and zero steps:** steps=0 behaves as steps=1; `enable`=0 for 10 clocks → `leds` holds, no `step_pulse`, and the count resumes where it stopped.
- **OFF request in RUN:** → `leds`=0000 at the next boundary; after ack completes, `busy`=0 and the FSM is in IDLE.
